// File: rtl/pdm_cic_decim_pkg.sv
// pdm_cic_decim_pkg: shared CIC order, width/shift formulas and warm-up state type
package pdm_cic_decim_pkg;
  localparam int C_CIC_ORDER = 3;
  typedef enum logic [1:0] {WARM0, WARM1, WARM2, RUN} cic_state_t;
  function automatic int cic_w(input int decim_log2);
    return C_CIC_ORDER * decim_log2 + 2;
  endfunction
  function automatic int cic_s(input int decim_log2, input int out_w);
    return C_CIC_ORDER * decim_log2 - (out_w - 1);
  endfunction
endpackage

// File: rtl/pdm_cic_decim_cic3_ch.sv
// pdm_cic_decim_cic3_ch: one PDM channel of the 3rd-order CIC (integrators, combs, shift, saturation)
module pdm_cic_decim_cic3_ch
  import pdm_cic_decim_pkg::*;
#(
  parameter int C_DECIM_LOG2 = 6,
  parameter int C_OUT_W      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ee,
  input  logic                      i_pdm,
  input  logic                      i_ld,
  input  logic [2:0]                i_en,
  input  logic                      i_upd,
  output logic signed [C_OUT_W-1:0] o_pcm,
  output logic                      o_sat
);
  localparam int W = cic_w(C_DECIM_LOG2);
  localparam int S = cic_s(C_DECIM_LOG2, C_OUT_W);
  localparam logic signed [W-1:0] P_MAX = W'((2 ** (C_OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] P_MIN = -P_MAX - W'(1);
  logic signed [W-1:0] r_i1, r_i2, r_i3, r_s0, r_c1, r_c2, r_c3, r_d1, r_d2, r_d3;
  logic signed [W-1:0] w_x, w_i1, w_i2, w_i3, w_sh;
  logic                w_clip;
  // integrators chain combinationally so r_i3 after the update is the post-update sum
  always_comb begin
    w_x    = i_pdm ? W'(1) : '1;
    w_i1   = r_i1 + w_x;
    w_i2   = r_i2 + w_i1;
    w_i3   = r_i3 + w_i2;
    w_sh   = r_c3 >>> S;
    w_clip = (w_sh > P_MAX) || (w_sh < P_MIN);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_i3  <= '0;
      r_s0  <= '0;
      r_c1  <= '0;
      r_c2  <= '0;
      r_c3  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_d3  <= '0;
      o_pcm <= '0;
      o_sat <= 1'b0;
    end else begin
      if (i_ee) begin
        r_i1 <= w_i1;
        r_i2 <= w_i2;
        r_i3 <= w_i3;
      end
      if (i_ld) r_s0 <= w_i3;
      if (i_en[0]) begin
        r_c1 <= r_s0 - r_d1;
        r_d1 <= r_s0;
      end
      if (i_en[1]) begin
        r_c2 <= r_c1 - r_d2;
        r_d2 <= r_c1;
      end
      if (i_en[2]) begin
        r_c3 <= r_c2 - r_d3;
        r_d3 <= r_c2;
      end
      if (i_upd) begin
        o_pcm <= w_clip ? (w_sh[W-1] ? P_MIN[C_OUT_W-1:0] : P_MAX[C_OUT_W-1:0]) : w_sh[C_OUT_W-1:0];
        o_sat <= w_clip;
      end
    end
  end
endmodule

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: dual-channel PDM to PCM CIC decimator with shared counter, warm-up FSM and valid pipeline
module pdm_cic_decim
  import pdm_cic_decim_pkg::*;
#(
  parameter int C_DECIM_LOG2 = 6,
  parameter int C_OUT_W      = 16
) (
  input  logic                      CK_i,
  input  logic                      ARST_i,
  input  logic                      EE_i,
  input  logic [1:0]                PDMs_i,
  output logic signed [C_OUT_W-1:0] PCM0_o,
  output logic signed [C_OUT_W-1:0] PCM1_o,
  output logic                      VLD_o,
  output logic [1:0]                SATs_o
);
  cic_state_t              r_state;
  logic [C_DECIM_LOG2-1:0] r_cnt;
  logic [2:0]              r_p;
  logic [3:0]              r_t;
  logic                    w_evt;
  logic signed [C_OUT_W-1:0] w_pcm [2];
  assign w_evt  = EE_i && (r_cnt == '1);
  assign PCM0_o = w_pcm[0];
  assign PCM1_o = w_pcm[1];
  // r_p steps the comb stages for every event; r_t carries only events taken in RUN
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_state <= WARM0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_t     <= '0;
      VLD_o   <= 1'b0;
    end else begin
      if (EE_i) r_cnt <= r_cnt + 1'b1;
      if (w_evt) r_state <= (r_state == RUN) ? RUN : cic_state_t'(r_state + 2'd1);
      r_p   <= {r_p[1:0], w_evt};
      r_t   <= {r_t[2:0], w_evt && (r_state == RUN)};
      VLD_o <= r_t[3];
    end
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    pdm_cic_decim_cic3_ch #(
      .C_DECIM_LOG2(C_DECIM_LOG2),
      .C_OUT_W     (C_OUT_W)
    ) u_ch (
      .i_clk(CK_i),
      .i_rst(ARST_i),
      .i_ee (EE_i),
      .i_pdm(PDMs_i[c]),
      .i_ld (w_evt),
      .i_en (r_p),
      .i_upd(r_t[3]),
      .o_pcm(w_pcm[c]),
      .o_sat(SATs_o[c])
    );
  end
endmodule

// File: tb/tb_pdm_cic_decim.sv
// tb_pdm_cic_decim: random and directed PDM stimulus checked every cycle against a
// convolution model of the CIC (boxcar^3 impulse response over +/-1 history).
module tb_pdm_cic_decim;
  localparam int L = 6, R = 64, OW = 16, S = 3 * L - (OW - 1), TAPS = 3 * R - 2;
  logic CK_i = 1'b0, ARST_i = 1'b1, EE_i = 1'b0;
  logic [1:0] PDMs_i = 2'b00;
  logic signed [OW-1:0] PCM0_o, PCM1_o;
  logic VLD_o;
  logic [1:0] SATs_o;

  pdm_cic_decim #(.C_DECIM_LOG2(L), .C_OUT_W(OW)) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .EE_i(EE_i), .PDMs_i(PDMs_i),
    .PCM0_o(PCM0_o), .PCM1_o(PCM1_o), .VLD_o(VLD_o), .SATs_o(SATs_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct {int c; int p0; int p1; logic [1:0] s;} exp_t;
  exp_t pend[$];
  int q0[$], q1[$];
  int h[TAPS];
  int checks = 0, errors = 0, cyc = 0, vld_cnt = 0, ee_cnt = 0, evt_n = 0;
  int exp_p0 = 0, exp_p1 = 0;
  logic [1:0] exp_s = 2'b00;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, want);
    end
  endtask

  function automatic int cic_raw(input int q[$]);
    int y = 0;
    for (int k = 0; k < TAPS; k++) begin
      int idx = q.size() - 1 - k;
      if (idx >= 0) y += h[k] * q[idx];
    end
    return y;
  endfunction

  function automatic void pcm_of(input int q[$], output int p, output logic c);
    int sh = cic_raw(q) >>> S;
    c = (sh > 32767) || (sh < -32768);
    p = (sh > 32767) ? 32767 : (sh < -32768) ? -32768 : sh;
  endfunction

  function automatic logic [1:0] pat(input int kind, input int n);
    logic [1:0] r = 2'($urandom);
    return kind == 0 ? 2'b11 : kind == 1 ? 2'b00 : kind == 2 ? (n % 2 == 0 ? 2'b11 : 2'b00) :
           kind == 3 ? 2'b01 : r;
  endfunction

  task automatic step(input logic ee, input logic [1:0] d);
    int p0, p1;
    logic c0, c1;
    @(negedge CK_i);
    EE_i = ee;
    PDMs_i = d;
    if (ee) begin
      q0.push_back(d[0] ? 1 : -1);
      q1.push_back(d[1] ? 1 : -1);
      if (q0.size() > TAPS) void'(q0.pop_front());
      if (q1.size() > TAPS) void'(q1.pop_front());
      if (ee_cnt == R - 1) begin
        evt_n++;
        if (evt_n > 3) begin
          pcm_of(q0, p0, c0);
          pcm_of(q1, p1, c1);
          pend.push_back('{cyc + 5, p0, p1, {c1, c0}});
        end
      end
      ee_cnt = (ee_cnt + 1) % R;
    end
  endtask

  task automatic do_reset();
    @(negedge CK_i);
    ARST_i = 1'b1;
    EE_i = 1'b0;
    pend.delete();
    q0.delete();
    q1.delete();
    exp_p0 = 0;
    exp_p1 = 0;
    exp_s = 2'b00;
    ee_cnt = 0;
    evt_n = 0;
    repeat (3) step(1'b0, 2'b00);
    @(negedge CK_i);
    ARST_i = 1'b0;
  endtask

  task automatic run_events(input int kind, input int nevt, input bit rnd);
    for (int i = 0; i < nevt * R; i++) begin
      int gap = rnd ? int'($urandom_range(1, 12)) : 12;
      logic [1:0] d = pat(kind, i);
      step(1'b1, d);
      repeat (gap - 1) step(1'b0, d);
    end
    repeat (8) step(1'b0, 2'b00);
  endtask

  task automatic phase(input int kind, input int nevt, input bit rnd, input bit lit,
                       input int l0, input int l1, input int ls);
    do_reset();
    vld_cnt = 0;
    run_events(kind, nevt, rnd);
    chk("vld_count", vld_cnt, nevt - 3);
    if (lit) begin
      chk("lit_pcm0", PCM0_o, l0);
      chk("lit_pcm1", PCM1_o, l1);
      chk("lit_sat", SATs_o, ls);
    end
  endtask

  initial begin
    exp_t e;
    int expv;
    forever begin
      @(posedge CK_i);
      #1;
      cyc++;
      expv = 0;
      if (pend.size() > 0 && pend[0].c == cyc) begin
        e = pend.pop_front();
        exp_p0 = e.p0;
        exp_p1 = e.p1;
        exp_s = e.s;
        expv = 1;
      end
      if (VLD_o) vld_cnt++;
      chk("vld", VLD_o, expv);
      chk("pcm0", PCM0_o, exp_p0);
      chk("pcm1", PCM1_o, exp_p1);
      chk("sat", SATs_o, exp_s);
    end
  end

  initial begin
    int b2[2*R-1];
    int qa[$], qb[$], qc[$];
    int p;
    logic c;
    for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int k = 0; k < 2 * R - 1; k++) for (int j = 0; j < R; j++) h[k+j] += b2[k];
    chk("model_h0", h[0], 1);
    chk("model_h1", h[1], 3);
    chk("model_h2", h[2], 6);
    for (int i = 0; i < TAPS; i++) begin
      qa.push_back(1);
      qb.push_back(i % 2 == 0 ? 1 : -1);
      qc.push_back(-1);
    end
    chk("model_gain", cic_raw(qa), 262144);
    chk("model_alt", cic_raw(qb), 0);
    pcm_of(qa, p, c);
    chk("model_ones_pcm", p, 32767);
    chk("model_ones_sat", int'(c), 1);
    pcm_of(qc, p, c);
    chk("model_zeros_pcm", p, -32768);
    chk("model_zeros_sat", int'(c), 0);

    phase(0, 7, 1'b0, 1'b1, 32767, 32767, 3);
    phase(1, 7, 1'b0, 1'b1, -32768, -32768, 0);
    phase(2, 7, 1'b0, 1'b1, 0, 0, 0);
    phase(3, 7, 1'b0, 1'b1, 32767, -32768, 1);
    phase(4, 12, 1'b1, 1'b0, 0, 0, 0);

    do_reset();
    vld_cnt = 0;
    run_events(0, 4, 1'b0);
    for (int i = 0; i < R; i++) begin
      step(1'b1, 2'b11);
      if (i < R - 1) repeat (11) step(1'b0, 2'b11);
    end
    repeat (2) step(1'b0, 2'b11);
    do_reset();
    repeat (8) step(1'b0, 2'b00);
    chk("rst_vld_count", vld_cnt, 1);
    chk("rst_pcm0", PCM0_o, 0);
    chk("rst_pcm1", PCM1_o, 0);
    chk("rst_sat", SATs_o, 0);
    run_events(0, 3, 1'b0);
    chk("rewarm_vld_count", vld_cnt, 1);
    chk("rewarm_pcm0", PCM0_o, 0);
    run_events(0, 1, 1'b0);
    chk("resume_vld_count", vld_cnt, 2);
    chk("resume_pcm0", PCM0_o, 32767);
    chk("resume_sat", SATs_o, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
